canny_window_scheduler: RTL and testbench
=========================================

CANNY_WINDOW_SCHEDULER -- requirements
Module: canny_window_scheduler

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels (>=3).
REQ-002 Parameter IMG_H, default 8, image height in pixels (>=3).
REQ-003 Parameter TIMEOUT, default 1024, maximum engine cycles per window before error.
REQ-004 Clock  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_pix  in  8  raster-order pixel, unsigned.
REQ-007 in_valid / in_ready  in / out  1 each  pixel handshake; transfer when both high.
REQ-008 eng_reset  out  1  drives 3x3 edge engine reset.
REQ-009 eng_enable  out  1  drives engine Enable.
REQ-010 eng_win  out  216  packed 3x3 window to engine A port.
REQ-011 eng_done / eng_gm  in  1 / 216  engine completion flag and thresholded result.
REQ-012 out_gm  out  216  captured engine result.
REQ-013 out_row / out_col  out  16 each  top-left coordinate of the window for out_gm.
REQ-014 out_valid / out_ready  out / in  1 each  result handshake.
REQ-015 frame_done  out  1  one-cycle pulse after the last window of a frame is accepted.
REQ-016 err_timeout  out  1  sticky engine-timeout flag.

Function
REQ-017 FSM states SHALL be FILL, LOAD, RUN, HOLD.
REQ-018 in_ready SHALL be high only in FILL.
REQ-019 Each accepted pixel SHALL be stored in a two-row line buffer and shift the 3x3 window left by one column; new right column = {row-2 buffer, row-1 buffer, in_pix}.
REQ-020 Column/row counters SHALL advance per accepted pixel, wrapping col at IMG_W-1 and row at IMG_H-1.
REQ-021 FILL->LOAD when the accepted pixel has row>=2 and col>=2; otherwise remain in FILL.
REQ-022 eng_win element r*3+c SHALL occupy bits [(r*3+c)*24 +: 24]; r=0 oldest row, c=0 leftmost column; each pixel zero-extended to 24 bits.
REQ-023 eng_win SHALL be held stable from LOAD entry until HOLD exit.
REQ-024 LOAD SHALL last exactly one cycle with eng_reset=1, eng_enable=0; then go to RUN.
REQ-025 RUN SHALL hold eng_enable=1, eng_reset=0 and count cycles; on eng_done=1, capture eng_gm into out_gm, deassert eng_enable next cycle, go to HOLD.
REQ-026 If the RUN count reaches TIMEOUT without eng_done, set err_timeout, load out_gm=0, go to HOLD.
REQ-027 HOLD SHALL assert out_valid with out_gm/out_row/out_col stable until out_ready; on transfer go to FILL.
REQ-028 out_row/out_col SHALL equal (pixel row-2, pixel col-2) of the triggering pixel.
REQ-029 frame_done SHALL pulse in the cycle after the HOLD transfer whose window's triggering pixel was (IMG_H-1, IMG_W-1).
REQ-030 Windows SHALL NOT span a row wrap: no window is issued for col<2.
REQ-031 eng_done while not in RUN SHALL be ignored.

Reset
REQ-032 On reset: state FILL, counters 0, line buffer and window 0, in_ready=1 next cycle, eng_reset=1 for that cycle, eng_enable=0, out_valid=0, out_gm=0, out_row=out_col=0, frame_done=0, err_timeout=0.
REQ-033 Reset asserted mid-RUN or mid-HOLD SHALL abandon the window; no out_valid is produced for it.

Structure
REQ-034 Shared package SHALL hold PIX_W=8, ELEM_W=24, WIN_W=216 and the FSM state encoding.
REQ-035 One sub-module, canny_line_buffer (two IMG_W x 8 row memories plus 3x3 window shift registers), SHALL be instantiated.

Verification
REQ-036 IMG_W=IMG_H=4, pixels 0..15, stub engine returns done after 5 cycles with gm=win -> 4 windows at (0,0),(0,1),(1,0),(1,1); first window elements 0,1,2,4,5,6,8,9,10; frame_done once.
REQ-037 out_ready held low 20 cycles during HOLD -> out_valid and out_gm stable, in_ready=0 throughout.
REQ-038 Stub engine never asserts done, TIMEOUT=16 -> err_timeout=1 at RUN cycle 16, out_gm=0, scheduler continues with next window.
REQ-039 reset pulsed during RUN of window (1,0) -> eng_enable=0, eng_reset=1 next cycle, no output for that window, next frame starts at (0,0).
REQ-040 in_valid toggled randomly 50% with constant pixel 200 -> every window element =200, window count per 8x8 frame =36.

Source files
------------

// File: rtl/canny_window_scheduler_pkg.sv
// Shared widths, FSM encoding and window packing for the Canny window scheduler.
// Element r*3+c of a packed window holds pixel (row r, column c), zero-extended.
package canny_window_scheduler_pkg;

  localparam int PIX_W  = 8;
  localparam int ELEM_W = 24;
  localparam int WIN_W  = 216;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // win[r][c]: r=0 is the oldest row, c=0 the leftmost column
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  function automatic logic [WIN_W-1:0] pack_window(input win_t w);
    logic [WIN_W-1:0] p;
    p = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[(r*3+c)*ELEM_W +: ELEM_W] = {{(ELEM_W-PIX_W){1'b0}}, w[r][c]};
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/canny_line_buffer.sv
// Two-row line buffer feeding a 3x3 sliding window; every accepted pixel
// shifts the window left and inserts {row-2, row-1, current} as the new right column.
module canny_line_buffer
  import canny_window_scheduler_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic [AW-1:0]    col,
  input  logic [PIX_W-1:0] in_pix,
  output win_t             win
);

  logic [PIX_W-1:0] row1_mem_r [IMG_W];
  logic [PIX_W-1:0] row2_mem_r [IMG_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IMG_W; i++) begin
        row1_mem_r[i] <= '0;
        row2_mem_r[i] <= '0;
      end
      win <= '0;
    end else if (shift) begin
      row2_mem_r[col] <= row1_mem_r[col];
      row1_mem_r[col] <= in_pix;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= row2_mem_r[col];
      win[1][2] <= row1_mem_r[col];
      win[2][2] <= in_pix;
    end
  end

endmodule

// File: rtl/canny_window_scheduler.sv
// Streams raster pixels into 3x3 windows, runs each through an external edge
// engine (with timeout) and presents the result on a ready/valid port.
module canny_window_scheduler
  import canny_window_scheduler_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             eng_reset,
  output logic             eng_enable,
  output logic [WIN_W-1:0] eng_win,
  input  logic             eng_done,
  input  logic [WIN_W-1:0] eng_gm,
  output logic [WIN_W-1:0] out_gm,
  output logic [15:0]      out_row,
  output logic [15:0]      out_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             err_timeout
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [15:0]   COL_LAST = 16'(IMG_W - 1);
  localparam logic [15:0]   ROW_LAST = 16'(IMG_H - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT - 1);

  state_t        state_r;
  state_t        state_s;
  logic [15:0]   col_r;
  logic [15:0]   row_r;
  logic [CW-1:0] run_cnt_r;
  logic          last_win_r;
  logic          accept_s;
  logic          trigger_s;
  logic          done_s;
  logic          expire_s;
  win_t          win_s;

  assign accept_s  = in_valid && in_ready;
  assign trigger_s = accept_s && (row_r >= 16'd2) && (col_r >= 16'd2);
  assign done_s    = (state_r == ST_RUN) && eng_done;
  assign expire_s  = (state_r == ST_RUN) && !eng_done && (run_cnt_r == RUN_LAST);

  canny_line_buffer #(
    .IMG_W (IMG_W),
    .AW    (AW)
  ) u_line_buffer (
    .clk    (clk),
    .reset  (reset),
    .shift  (accept_s),
    .col    (col_r[AW-1:0]),
    .in_pix (in_pix),
    .win    (win_s)
  );

  // The window only shifts in FILL, so it is frozen from LOAD until HOLD exits
  assign eng_win = pack_window(win_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_s;
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (trigger_s) state_s = ST_LOAD;
        else           state_s = ST_FILL;
      end
      ST_LOAD: state_s = ST_RUN;
      ST_RUN: begin
        if (done_s || expire_s) state_s = ST_HOLD;
        else                    state_s = ST_RUN;
      end
      ST_HOLD: begin
        if (out_ready) state_s = ST_FILL;
        else           state_s = ST_HOLD;
      end
      default: state_s = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_r      <= 16'd0;
      row_r      <= 16'd0;
      run_cnt_r  <= '0;
      last_win_r <= 1'b0;
      out_row    <= 16'd0;
      out_col    <= 16'd0;
    end else begin
      if (accept_s) begin
        col_r <= (col_r == COL_LAST) ? 16'd0 : col_r + 16'd1;
        if (col_r == COL_LAST) row_r <= (row_r == ROW_LAST) ? 16'd0 : row_r + 16'd1;
      end
      if (trigger_s) begin
        out_row    <= row_r - 16'd2;
        out_col    <= col_r - 16'd2;
        last_win_r <= (row_r == ROW_LAST) && (col_r == COL_LAST);
      end
      run_cnt_r <= (state_r == ST_RUN) ? run_cnt_r + 1'b1 : '0;
    end
  end

  // Handshake/engine controls are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready    <= 1'b1;
      eng_reset   <= 1'b1;
      eng_enable  <= 1'b0;
      out_valid   <= 1'b0;
      out_gm      <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      in_ready   <= (state_s == ST_FILL);
      eng_reset  <= (state_s == ST_LOAD);
      eng_enable <= (state_s == ST_RUN);
      out_valid  <= (state_s == ST_HOLD);
      frame_done <= (state_r == ST_HOLD) && out_ready && last_win_r;
      if (done_s) begin
        out_gm <= eng_gm;
      end else if (expire_s) begin
        out_gm      <= '0;
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_canny_window_scheduler.sv
// Randomized bench for canny_window_scheduler: a 4x4/TIMEOUT=16 instance and an
// 8x8 instance, each with a stub engine, checked against windows cut from a 2D image.
module tb_canny_window_scheduler;

  logic         clk = 1'b0;
  logic         reset       [2];
  logic [7:0]   in_pix      [2];
  logic         in_valid    [2];
  logic         in_ready    [2];
  logic         eng_reset   [2];
  logic         eng_enable  [2];
  logic [215:0] eng_win     [2];
  logic         eng_done    [2];
  logic [215:0] eng_gm      [2];
  logic [215:0] out_gm      [2];
  logic [15:0]  out_row     [2];
  logic [15:0]  out_col     [2];
  logic         out_valid   [2];
  logic         out_ready   [2];
  logic         frame_done  [2];
  logic         err_timeout [2];

  logic [7:0]   ecnt       [2];
  logic         stray      [2];
  bit           never_done [2];

  int           checks = 0;
  int           errors = 0;
  int           img [64];
  logic [215:0] first_gm;
  logic [15:0]  first_row;
  logic [15:0]  first_col;

  always #5 clk = ~clk;

  canny_window_scheduler #(.IMG_W(4), .IMG_H(4), .TIMEOUT(16)) dut0 (
    .clk(clk), .reset(reset[0]), .in_pix(in_pix[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .eng_reset(eng_reset[0]), .eng_enable(eng_enable[0]),
    .eng_win(eng_win[0]), .eng_done(eng_done[0]), .eng_gm(eng_gm[0]),
    .out_gm(out_gm[0]), .out_row(out_row[0]), .out_col(out_col[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .frame_done(frame_done[0]), .err_timeout(err_timeout[0])
  );

  canny_window_scheduler #(.IMG_W(8), .IMG_H(8), .TIMEOUT(1024)) dut1 (
    .clk(clk), .reset(reset[1]), .in_pix(in_pix[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .eng_reset(eng_reset[1]), .eng_enable(eng_enable[1]),
    .eng_win(eng_win[1]), .eng_done(eng_done[1]), .eng_gm(eng_gm[1]),
    .out_gm(out_gm[1]), .out_row(out_row[1]), .out_col(out_col[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .frame_done(frame_done[1]), .err_timeout(err_timeout[1])
  );

  // Stub engine: done in the 5th enabled cycle with gm = window; random
  // spurious done (with garbage gm) whenever it is not enabled.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (eng_reset[k])       ecnt[k] <= 8'd0;
      else if (eng_enable[k]) ecnt[k] <= ecnt[k] + 8'd1;
    end
  end

  assign eng_done[0] = eng_enable[0] ? (!never_done[0] && ecnt[0] == 8'd4) : stray[0];
  assign eng_done[1] = eng_enable[1] ? (!never_done[1] && ecnt[1] == 8'd4) : stray[1];
  assign eng_gm[0]   = eng_enable[0] ? eng_win[0] : {216{1'b1}};
  assign eng_gm[1]   = eng_enable[1] ? eng_win[1] : {216{1'b1}};

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    reset[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0; stray[k] = 1'b0;
    tick();
    reset[k] = 1'b0;
    tick();
  endtask

  // Streams img[0..w*h-1] into DUT k and checks every output against windows
  // cut directly from the image. abort3 resets the DUT during the 3rd window's RUN.
  task automatic run_frame(input int k, input int w, input int h, input int pvalid,
                           input int pready, input int stall, input bit abort3,
                           output int nwin);
    int n, pi, got, cyc, nexp, runlen, fd;
    logic [215:0] g, pgm;
    logic [15:0]  prow, pcol;
    bit pstall, plast, pen, in_fire, out_fire, aborted;
    logic [215:0] eg [$];
    int er [$];
    int ec [$];
    n = w * h; pi = 0; got = 0; cyc = 0; runlen = 0; fd = 0;
    pstall = 1'b0; plast = 1'b0; pen = 1'b0; aborted = 1'b0;
    pgm = '0; prow = '0; pcol = '0;
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        g = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            g[(i*3+j)*24 +: 24] = 24'(img[(r-2+i)*w + (c-2+j)]);
        eg.push_back(never_done[k] ? 216'd0 : g);
        er.push_back(r - 2);
        ec.push_back(c - 2);
      end
    end
    nexp = eg.size();
    while ((pi < n || got < nexp) && cyc < 4000) begin
      if (abort3 && got == 2 && eng_enable[k]) begin
        reset[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b1; stray[k] = 1'b0;
        tick();
        reset[k] = 1'b0;
        chk("abort_eng_enable", eng_enable[k], 1'b0);
        chk("abort_eng_reset", eng_reset[k], 1'b1);
        chk("abort_out_valid", out_valid[k], 1'b0);
        aborted = 1'b1;
        break;
      end
      in_valid[k] = (pi < n) && ($urandom_range(99) < pvalid);
      in_pix[k]   = 8'(img[(pi < n) ? pi : 0]);
      stray[k]    = 1'($urandom_range(1));
      if (stall > 0 && out_valid[k]) begin
        out_ready[k] = 1'b0;
        stall--;
      end else begin
        out_ready[k] = ($urandom_range(99) < pready);
      end
      chk("in_ready_outside_fill", in_ready[k] & (out_valid[k] | eng_enable[k]), 1'b0);
      chk("frame_done", frame_done[k], plast);
      if (frame_done[k]) fd++;
      if (pstall) begin
        chk("hold_valid", out_valid[k], 1'b1);
        chk("hold_gm", out_gm[k], pgm);
        chk("hold_row", out_row[k], prow);
        chk("hold_col", out_col[k], pcol);
      end
      if (eng_enable[k]) begin
        runlen++;
      end else if (pen) begin
        chk("run_length", runlen, never_done[k] ? 16 : 5);
        chk("err_timeout_run", err_timeout[k], never_done[k]);
        runlen = 0;
      end
      pen = eng_enable[k];
      out_fire = out_valid[k] && out_ready[k];
      in_fire  = in_valid[k] && in_ready[k];
      if (out_fire) begin
        if (got < nexp) begin
          chk("out_gm", out_gm[k], eg[got]);
          chk("out_row", out_row[k], er[got]);
          chk("out_col", out_col[k], ec[got]);
          chk("err_timeout_out", err_timeout[k], never_done[k]);
          if (got == 0) begin
            first_gm = out_gm[k]; first_row = out_row[k]; first_col = out_col[k];
          end
        end else begin
          chk("extra_window", 1'b1, 1'b0);
        end
        got++;
      end
      pstall = out_valid[k] && !out_ready[k];
      pgm = out_gm[k]; prow = out_row[k]; pcol = out_col[k];
      plast = out_fire && out_row[k] == 16'(h - 3) && out_col[k] == 16'(w - 3);
      tick();
      if (in_fire) pi++;
      cyc++;
    end
    in_valid[k] = 1'b0; out_ready[k] = 1'b0; stray[k] = 1'b0;
    chk("cycle_budget", cyc < 4000, 1'b1);
    if (!aborted) begin
      chk("frame_done_final", frame_done[k], plast);
      if (frame_done[k]) fd++;
      chk("frame_done_count", fd, 1);
      tick();
    end
    nwin = got;
  endtask

  initial begin
    int nwin;
    int fw [9];
    fw = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; in_valid[k] = 1'b0; in_pix[k] = 8'd0;
      out_ready[k] = 1'b0; stray[k] = 1'b0; never_done[k] = 1'b0;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", in_ready[k], 1'b1);
      chk("rst_eng_reset", eng_reset[k], 1'b1);
      chk("rst_eng_enable", eng_enable[k], 1'b0);
      chk("rst_out_valid", out_valid[k], 1'b0);
      chk("rst_out_gm", out_gm[k], 216'd0);
      chk("rst_out_row", out_row[k], 16'd0);
      chk("rst_out_col", out_col[k], 16'd0);
      chk("rst_frame_done", frame_done[k], 1'b0);
      chk("rst_err_timeout", err_timeout[k], 1'b0);
      reset[k] = 1'b0;
    end
    tick();
    chk("post_rst_eng_reset", eng_reset[0], 1'b0);
    chk("post_rst_in_ready", in_ready[0], 1'b1);

    // 4x4 ramp 0..15, full-rate handshakes
    for (int i = 0; i < 16; i++) img[i] = i;
    run_frame(0, 4, 4, 100, 100, 0, 1'b0, nwin);
    chk("ramp_windows", nwin, 4);
    for (int e = 0; e < 9; e++) chk("first_elem", first_gm[e*24 +: 24], fw[e]);

    // random image, 20-cycle stall on the first result, then random ready
    do_reset(0);
    for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(255));
    run_frame(0, 4, 4, 80, 50, 20, 1'b0, nwin);
    chk("stall_windows", nwin, 4);

    // engine never finishes
    do_reset(0);
    never_done[0] = 1'b1;
    for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(255));
    run_frame(0, 4, 4, 100, 100, 0, 1'b0, nwin);
    chk("timeout_windows", nwin, 4);
    chk("timeout_sticky", err_timeout[0], 1'b1);
    never_done[0] = 1'b0;

    // reset during RUN of window (1,0), then a fresh frame
    do_reset(0);
    for (int i = 0; i < 16; i++) img[i] = i;
    run_frame(0, 4, 4, 100, 100, 0, 1'b1, nwin);
    chk("abort_windows", nwin, 2);
    out_ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_output", out_valid[0], 1'b0);
    end
    out_ready[0] = 1'b0;
    run_frame(0, 4, 4, 100, 100, 0, 1'b0, nwin);
    chk("restart_windows", nwin, 4);
    chk("restart_first_row", first_row, 16'd0);
    chk("restart_first_col", first_col, 16'd0);

    // 8x8 constant 200 with 50% input valid
    for (int i = 0; i < 64; i++) img[i] = 200;
    run_frame(1, 8, 8, 50, 70, 0, 1'b0, nwin);
    chk("const_windows", nwin, 36);
    chk("const_err_timeout", err_timeout[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
